// File: rtl/memory_controller_pkg.sv
// Shared widths, op encodings and controller state encoding.
// No logic; types and constants only.
// Imported by every memory-controller file and by the bench.
package memory_controller_pkg;

  localparam int XLEN           = 32;
  localparam int INST_OP_WIDTH  = 4;
  localparam int ROB_SIZE_WIDTH = 4;

  // First IO-mapped address; IO stores honour io_buffer_full per byte.
  localparam logic [XLEN-1:0] MC_IO_ADDR = 32'h0003_0000;

  localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 4'd0;
  localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 4'd1;
  localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 4'd2;
  localparam logic [INST_OP_WIDTH-1:0] OP_LBU = 4'd3;
  localparam logic [INST_OP_WIDTH-1:0] OP_LHU = 4'd4;
  localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 4'd5;
  localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 4'd6;
  localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 4'd7;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_LOAD  = 2'd1,
    MC_STORE = 2'd2,
    MC_FETCH = 2'd3
  } mc_state_t;

  // Number of bus bytes an access of this op occupies.
  function automatic logic [2:0] op_bytes(input logic [INST_OP_WIDTH-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
      default:              op_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mc_load_extend.sv
// Sign/zero extension of an assembled little-endian load word by op.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mc_load_extend
  import memory_controller_pkg::*;
(
  input  logic [XLEN-1:0]          raw,
  input  logic [INST_OP_WIDTH-1:0] op,
  output logic [XLEN-1:0]          ext
);

  // Only the low bytes that were actually fetched are meaningful for B/H ops.
  always_comb begin
    ext = raw;
    case (op)
      OP_LB:   ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
      OP_LBU:  ext = {{(XLEN-8){1'b0}}, raw[7:0]};
      OP_LH:   ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
      OP_LHU:  ext = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/memory_controller.sv
// Serialises loads, committed stores and fetches onto a byte-wide RAM/IO bus.
// Latency: issue T, bytes on bus T+1..T+n, load/fetch result pulses at T+n+2.
// Backpressure: mem_busy blocks new load/store; IO stores stall on io_buffer_full.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter logic [XLEN-1:0] IO_ADDR = MC_IO_ADDR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      io_buffer_full,
  input  logic                      lsb_mem_enable,
  input  logic [INST_OP_WIDTH-1:0]  lsb_mem_op,
  input  logic [XLEN-1:0]           lsb_mem_addr,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id,
  input  logic                      rob_mem_enable,
  input  logic [INST_OP_WIDTH-1:0]  rob_mem_op,
  input  logic [XLEN-1:0]           rob_mem_addr,
  input  logic [XLEN-1:0]           rob_mem_data,
  input  logic                      if_enable,
  input  logic [XLEN-1:0]           if_addr,
  input  logic [7:0]                mem_din,
  output logic                      mem_busy,
  output logic                      mem_data_ready,
  output logic [XLEN-1:0]           mem_data,
  output logic [ROB_SIZE_WIDTH-1:0] mem_id,
  output logic                      mc_inst_ready,
  output logic [XLEN-1:0]           mc_inst,
  output logic [7:0]                mem_dout,
  output logic [XLEN-1:0]           mem_a,
  output logic                      mem_wr
);

  mc_state_t state, state_nxt;

  // Pending slots
  logic                      ld_pend, st_pend;
  logic [INST_OP_WIDTH-1:0]  ld_op, st_op;
  logic [XLEN-1:0]           ld_addr, st_addr, st_data;
  logic [ROB_SIZE_WIDTH-1:0] ld_id;

  // Working registers of the access on the bus
  logic [XLEN-1:0]           w_addr, w_data;
  logic [INST_OP_WIDTH-1:0]  w_op;
  logic [ROB_SIZE_WIDTH-1:0] w_id;
  logic [2:0]                w_len, cnt;
  logic [3:0][7:0]           byte_buf, raw_bytes;
  logic [1:0]                lane;
  logic [XLEN-1:0]           byte_addr, ext_word;
  logic                      ready_q, inst_ready_q;

  logic issue_st, issue_ld, issue_if, finish_rd, io_stall, reading;

  assign io_stall  = (w_addr >= IO_ADDR) && io_buffer_full;
  assign byte_addr = w_addr + {{(XLEN-3){1'b0}}, cnt};
  assign lane      = 2'(cnt - 3'd1);
  assign reading   = (state == MC_LOAD) || (state == MC_FETCH);

  assign mem_busy = (state != MC_IDLE) | ld_pend | st_pend | lsb_mem_enable | rob_mem_enable;

  // A registered result must never surface during a flush or while frozen.
  assign mem_data_ready = ready_q & rdy & ~flush;
  assign mc_inst_ready  = inst_ready_q & rdy & ~flush;

  // Byte lane cnt-1 arrives on mem_din this cycle; merge it with earlier lanes.
  always_comb begin
    raw_bytes       = byte_buf;
    raw_bytes[lane] = mem_din;
  end

  mc_load_extend u_extend (
    .raw (raw_bytes),
    .op  (w_op),
    .ext (ext_word)
  );

  // Next-state and issue decision; store slot beats load slot beats fetch.
  always_comb begin
    state_nxt = state;
    issue_st  = 1'b0;
    issue_ld  = 1'b0;
    issue_if  = 1'b0;
    finish_rd = 1'b0;
    case (state)
      MC_IDLE: begin
        if (st_pend) begin
          issue_st  = 1'b1;
          state_nxt = MC_STORE;
        end else if (ld_pend && !flush) begin
          issue_ld  = 1'b1;
          state_nxt = MC_LOAD;
        end else if (if_enable && !flush) begin
          issue_if  = 1'b1;
          state_nxt = MC_FETCH;
        end
      end
      MC_LOAD, MC_FETCH: begin
        if (flush) begin
          state_nxt = MC_IDLE;
        end else if (cnt == w_len) begin
          finish_rd = 1'b1;
          state_nxt = MC_IDLE;
        end
      end
      MC_STORE: begin
        if (!io_stall && cnt == w_len - 3'd1) state_nxt = MC_IDLE;
      end
      default: state_nxt = MC_IDLE;
    endcase
  end

  // Bus drive: addresses while bytes are outstanding, write strobe only when allowed.
  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    if (reading && cnt < w_len) begin
      mem_a = byte_addr;
    end else if (state == MC_STORE) begin
      mem_a = byte_addr;
      if (!io_stall && rdy) begin
        mem_wr   = 1'b1;
        mem_dout = w_data[{cnt[1:0], 3'b000} +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)      state <= MC_IDLE;
    else if (rdy) state <= state_nxt;
  end

  // Slots, working registers, byte capture and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_pend <= 1'b0; ld_op <= '0; ld_addr <= '0; ld_id <= '0;
      st_pend <= 1'b0; st_op <= '0; st_addr <= '0; st_data <= '0;
      w_addr <= '0; w_data <= '0; w_op <= '0; w_id <= '0; w_len <= '0; cnt <= '0;
      byte_buf <= '0;
      ready_q <= 1'b0; inst_ready_q <= 1'b0;
      mem_data <= '0; mem_id <= '0; mc_inst <= '0;
    end else if (rdy) begin
      ready_q      <= finish_rd && (state == MC_LOAD);
      inst_ready_q <= finish_rd && (state == MC_FETCH);

      if (flush) begin
        ld_pend <= 1'b0;
      end else if (lsb_mem_enable) begin
        ld_pend <= 1'b1; ld_op <= lsb_mem_op; ld_addr <= lsb_mem_addr; ld_id <= lsb_mem_id;
      end else if (issue_ld) begin
        ld_pend <= 1'b0;
      end

      if (rob_mem_enable) begin
        st_pend <= 1'b1; st_op <= rob_mem_op; st_addr <= rob_mem_addr; st_data <= rob_mem_data;
      end else if (issue_st) begin
        st_pend <= 1'b0;
      end

      if (issue_st) begin
        w_addr <= st_addr; w_data <= st_data; w_op <= st_op;
        w_len <= op_bytes(st_op); cnt <= 3'd0;
      end else if (issue_ld) begin
        w_addr <= ld_addr; w_op <= ld_op; w_id <= ld_id;
        w_len <= op_bytes(ld_op); cnt <= 3'd0;
      end else if (issue_if) begin
        w_addr <= if_addr; w_op <= OP_LW; w_len <= 3'd4; cnt <= 3'd0;
      end else if (reading && !flush) begin
        if (cnt != 3'd0) byte_buf[lane] <= mem_din;
        if (!finish_rd) cnt <= cnt + 3'd1;
      end else if (state == MC_STORE && !io_stall) begin
        cnt <= cnt + 3'd1;
      end

      if (finish_rd && state == MC_LOAD) begin
        mem_data <= ext_word;
        mem_id   <= w_id;
      end
      if (finish_rd && state == MC_FETCH) mc_inst <= raw_bytes;
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller with a byte RAM and a reference memory.
// Latency: expected result cycles derived from request-pulse time.
// Backpressure: stimulus waits for mem_busy low before every new request.
module tb_memory_controller;
  import memory_controller_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, flush, io_buffer_full;
  logic        lsb_mem_enable, rob_mem_enable, if_enable;
  logic [3:0]  lsb_mem_op, rob_mem_op, lsb_mem_id;
  logic [31:0] lsb_mem_addr, rob_mem_addr, rob_mem_data, if_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_busy, mem_data_ready, mc_inst_ready, mem_wr;
  logic [31:0] mem_data, mc_inst, mem_a;
  logic [3:0]  mem_id;

  memory_controller dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
    .lsb_mem_enable(lsb_mem_enable), .lsb_mem_op(lsb_mem_op), .lsb_mem_addr(lsb_mem_addr),
    .lsb_mem_id(lsb_mem_id), .rob_mem_enable(rob_mem_enable), .rob_mem_op(rob_mem_op),
    .rob_mem_addr(rob_mem_addr), .rob_mem_data(rob_mem_data), .if_enable(if_enable),
    .if_addr(if_addr), .mem_din(mem_din), .mem_busy(mem_busy), .mem_data_ready(mem_data_ready),
    .mem_data(mem_data), .mem_id(mem_id), .mc_inst_ready(mc_inst_ready), .mc_inst(mc_inst),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  typedef struct { logic [31:0] data; logic [3:0] id; int cyc; } ld_t;
  typedef struct { logic [31:0] data; int cyc; } if_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;

  ld_t ldq[$];
  if_t ifq[$];
  wr_t wrq[$];
  ld_t ml;
  if_t mf;
  wr_t mw;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  logic [7:0] ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM with one cycle read latency.
  always @(posedge clk) begin
    if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and result pulse is matched against the queues.
  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_wr === 1'b1) begin
        if (wrq.size() == 0) chk("unexpected_write", {31'b0, mem_wr}, 32'd0);
        else begin
          mw = wrq.pop_front();
          chk("wr_addr", mem_a, mw.addr);
          chk("wr_data", {24'b0, mem_dout}, {24'b0, mw.data});
        end
      end
      if (mem_data_ready === 1'b1) begin
        if (ldq.size() == 0) chk("unexpected_load", {31'b0, mem_data_ready}, 32'd0);
        else begin
          ml = ldq.pop_front();
          chk("ld_data", mem_data, ml.data);
          chk("ld_id", {28'b0, mem_id}, {28'b0, ml.id});
          if (ml.cyc >= 0) chk("ld_cycle", cyc, ml.cyc);
        end
      end
      if (mc_inst_ready === 1'b1) begin
        if (ifq.size() == 0) chk("unexpected_fetch", {31'b0, mc_inst_ready}, 32'd0);
        else begin
          mf = ifq.pop_front();
          chk("if_data", mc_inst, mf.data);
          chk("if_cycle", cyc, mf.cyc);
        end
      end
    end
  end

  function automatic int nbytes(input logic [3:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Reference value: little-endian integer of n bytes, then signed view for LB/LH.
  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
    logic [31:0] w = 32'd0;
    for (int k = 0; k < nbytes(op); k++) w = w | (32'(ref_rd(a + 32'(k))) << (8 * k));
    if (op == OP_LB && w >= 32'h80)    return w - 32'h100;
    if (op == OP_LH && w >= 32'h8000)  return w - 32'h10000;
    return w;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mem_busy !== 1'b0 && n < 100) begin tick(); n++; end
    if (n >= 100) chk("idle_timeout", {31'b0, mem_busy}, 32'd0);
  endtask

  task automatic push_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < nbytes(op); k++) begin
      wrq.push_back('{a + 32'(k), d[8*k +: 8]});
      ref_mem[a + 32'(k)] = d[8*k +: 8];
    end
    rob_mem_op = op; rob_mem_addr = a; rob_mem_data = d;
  endtask

  task automatic push_load(input logic [3:0] op, input logic [31:0] a, input logic [3:0] id, input int c);
    ldq.push_back('{ref_load(op, a), id, c});
    lsb_mem_op = op; lsb_mem_addr = a; lsb_mem_id = id;
  endtask

  task automatic load_pulse(input logic [3:0] op, input logic [31:0] a, input logic [3:0] id);
    push_load(op, a, id, cyc + nbytes(op) + 3);
    lsb_mem_enable = 1'b1; tick(); lsb_mem_enable = 1'b0;
  endtask

  task automatic store_pulse(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    push_store(op, a, d);
    rob_mem_enable = 1'b1; tick(); rob_mem_enable = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, output int lat);
    ifq.push_back('{ref_load(OP_LW, a), cyc + 6});
    if_addr = a; if_enable = 1'b1; lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mc_inst_ready === 1'b1) begin lat = i; break; end
    end
    if_enable = 1'b0;
    if (lat < 0) chk("fetch_timeout", {31'b0, mc_inst_ready}, 32'd1);
    tick();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, viol, r;
    logic [3:0] ops_ld [5];
    logic [3:0] ops_st [3];
    ops_ld = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    ops_st = '{OP_SB, OP_SH, OP_SW};
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    lsb_mem_enable = 1'b0; rob_mem_enable = 1'b0; if_enable = 1'b0;
    lsb_mem_op = '0; lsb_mem_addr = '0; lsb_mem_id = '0;
    rob_mem_op = '0; rob_mem_addr = '0; rob_mem_data = '0; if_addr = '0;
    preload(32'h100, 8'h11); preload(32'h101, 8'h22); preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h104, 8'h80); preload(32'h105, 8'hFF);
    preload(32'h0, 8'h13); preload(32'h1, 8'h05); preload(32'h2, 8'hA0); preload(32'h3, 8'h7E);
    preload(32'hFFFF_FFFE, 8'hC3); preload(32'hFFFF_FFFF, 8'h5A);
    for (int i = 0; i < 64; i++) preload(32'h400 + 32'(i), 8'($urandom));
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_a", mem_a, 32'd0);
    chk("rst_busy", {31'b0, mem_busy}, 32'd0);
    chk("rst_ready", {30'b0, mem_data_ready, mc_inst_ready}, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    tick();
    rst = 1'b0; mon_on = 1'b1;
    tick();

    // LW with address sequence and 6-cycle latency.
    load_pulse(OP_LW, 32'h100, 4'd5);
    @(negedge clk); @(negedge clk);
    chk("lw_a_t1", mem_a, 32'h100);
    chk("lw_rd_t1", {31'b0, mem_wr}, 32'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("lw_a_t4", mem_a, 32'h103);
    tick();

    wait_idle(); load_pulse(OP_LB,  32'h104, 4'd1);
    wait_idle(); load_pulse(OP_LBU, 32'h104, 4'd2);
    wait_idle(); load_pulse(OP_LH,  32'h104, 4'd3);
    wait_idle(); load_pulse(OP_LHU, 32'h104, 4'd4);
    wait_idle(); load_pulse(OP_LW,  32'hFFFF_FFFE, 4'd6);

    // Store and load in the same cycle: store first, busy throughout.
    wait_idle();
    push_store(OP_SH, 32'h200, 32'h0000_BEEF);
    push_load(OP_LW, 32'h200, 4'd9, -1);
    rob_mem_enable = 1'b1; lsb_mem_enable = 1'b1; tick();
    rob_mem_enable = 1'b0; lsb_mem_enable = 1'b0;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_data_ready === 1'b1) break;
      if (mem_busy !== 1'b1) viol++;
    end
    chk("busy_st_ld", 32'(viol), 32'd0);
    tick();

    // IO store held by io_buffer_full for three cycles; a flush does not kill it.
    wait_idle();
    io_buffer_full = 1'b1;
    store_pulse(OP_SB, 32'h0003_0000, 32'h41);
    viol = 0;
    for (int i = 1; i <= 3; i++) begin
      tick(); flush = (i == 2);
      @(negedge clk);
      if (mem_wr !== 1'b0) viol++;
    end
    tick(); flush = 1'b0; io_buffer_full = 1'b0;
    @(negedge clk);
    chk("io_stall_wr", 32'(viol), 32'd0);
    chk("io_write", {31'b0, mem_wr}, 32'd1);
    tick();

    // rdy low freezes the store and blocks the strobe.
    wait_idle();
    store_pulse(OP_SB, 32'h180, 32'h5A);
    tick(); rdy = 1'b0;
    @(negedge clk);
    chk("rdy_low_wr", {31'b0, mem_wr}, 32'd0);
    tick(); rdy = 1'b1;
    @(negedge clk);
    chk("rdy_high_wr", {31'b0, mem_wr}, 32'd1);
    tick();

    // Flush two cycles into an LW aborts it; a fetch follows with full latency.
    wait_idle();
    lsb_mem_op = OP_LW; lsb_mem_addr = 32'h100; lsb_mem_id = 4'd7;
    lsb_mem_enable = 1'b1; tick(); lsb_mem_enable = 1'b0;
    tick(); tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    do_fetch(32'h0, lat);
    chk("fetch_after_flush", 32'(lat), 32'd6);

    // Flush exactly in the result cycle suppresses the pulse.
    wait_idle();
    lsb_mem_op = OP_LW; lsb_mem_addr = 32'h100; lsb_mem_id = 4'd8;
    lsb_mem_enable = 1'b1; tick(); lsb_mem_enable = 1'b0;
    repeat (6) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_suppress", {31'b0, mem_data_ready}, 32'd0);
    tick(); flush = 1'b0;

    // Randomised mix against the reference memory.
    for (int i = 0; i < 80; i++) begin
      wait_idle();
      r = $urandom_range(0, 9);
      if (r < 3) begin
        store_pulse(ops_st[$urandom_range(0, 2)], 32'h400 + $urandom_range(0, 60), $urandom);
      end else if (r < 7) begin
        load_pulse(ops_ld[$urandom_range(0, 4)], 32'h400 + $urandom_range(0, 60), 4'($urandom));
      end else if (r < 8) begin
        push_store(ops_st[$urandom_range(0, 2)], 32'h400 + $urandom_range(0, 60), $urandom);
        push_load(ops_ld[$urandom_range(0, 4)], 32'h400 + $urandom_range(0, 60), 4'($urandom), -1);
        rob_mem_enable = 1'b1; lsb_mem_enable = 1'b1; tick();
        rob_mem_enable = 1'b0; lsb_mem_enable = 1'b0;
      end else begin
        do_fetch(32'h400 + $urandom_range(0, 60), lat);
      end
    end
    wait_idle();
    repeat (10) tick();

    // Reset during a SW abandons the remaining bytes.
    wait_idle();
    rob_mem_op = OP_SW; rob_mem_addr = 32'h300; rob_mem_data = 32'hDEAD_BEEF;
    wrq.push_back('{32'h300, 8'hEF});
    wrq.push_back('{32'h301, 8'hBE});
    rob_mem_enable = 1'b1; tick(); rob_mem_enable = 1'b0;
    tick(); tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_sw_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_sw_a", mem_a, 32'd0);
    chk("rst_sw_busy", {31'b0, mem_busy}, 32'd0);
    chk("rst_sw_out", mem_data | mc_inst | {24'b0, mem_dout} | {28'b0, mem_id}, 32'd0);
    repeat (8) tick();

    chk("ldq_empty", 32'(ldq.size()), 32'd0);
    chk("ifq_empty", 32'(ifq.size()), 32'd0);
    chk("wrq_empty", 32'(wrq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
Responder side of the load/store request interface. It accepts load requests from the load/store buffer, committed store requests from the ROB, and instruction-fetch requests from the fetcher. It serialises all of them onto the byte-wide RAM/IO bus (one byte per cycle, little-endian) and returns results tagged with the ROB id. It sits between the out-of-order core and the external RAM/IO port.

Parameters:
IO_ADDR, 32'h30000, first IO-mapped address; stores whose address is at or above this wait for !io_buffer_full before each byte.
Widths `XLEN, `INST_OP_WIDTH and `ROB_SIZE_WIDTH come from global_params.v; they are not module parameters.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; when low, all state holds
flush  in  1  misprediction flush
io_buffer_full  in  1  UART/IO buffer full
lsb_mem_enable  in  1  load request valid (one-cycle pulse)
lsb_mem_op  in  `INST_OP_WIDTH  LB/LH/LW/LBU/LHU
lsb_mem_addr  in  `XLEN  load address
lsb_mem_id  in  `ROB_SIZE_WIDTH  ROB id of the load
rob_mem_enable  in  1  committed store valid (one-cycle pulse)
rob_mem_op  in  `INST_OP_WIDTH  SB/SH/SW
rob_mem_addr  in  `XLEN  store address
rob_mem_data  in  `XLEN  store data
if_enable  in  1  fetch request (level, held until served)
if_addr  in  `XLEN  fetch PC
mem_din  in  8  RAM/IO read byte
mem_busy  out  1  new load/store must not be issued
mem_data_ready  out  1  load result valid (one-cycle pulse)
mem_data  out  `XLEN  extended load result
mem_id  out  `ROB_SIZE_WIDTH  ROB id of the result
mc_inst_ready  out  1  fetch result valid (one-cycle pulse)
mc_inst  out  `XLEN  fetched word
mem_dout  out  8  write byte
mem_a  out  `XLEN  RAM/IO byte address
mem_wr  out  1  1 = write

Behaviour:
- Reset: every output is 0; state IDLE; pending slots empty; byte counter 0.
- Pending slots:
  - One load slot and one store slot.
  - A request pulse is latched into its slot the same cycle it arrives.
  - Both pulses in the same cycle are both latched.
- mem_busy is combinational: (state != IDLE) | load_pending | store_pending | lsb_mem_enable | rob_mem_enable.
- Issue (cycle T, state IDLE): priority is store slot > load slot > if_enable. Slot contents are copied into working registers and the slot is cleared. A request latched in cycle T is eligible from T+1.
- Byte count n: 1 for B/BU, 2 for H/HU, 4 for W and fetch.
- LOAD / FETCH:
  - mem_a = addr+k and mem_wr=0 in cycles T+1..T+n.
  - Byte k is sampled from mem_din in cycle T+2+k (RAM read latency is 1).
  - Assembly is little-endian. LB/LH sign-extend; LBU/LHU zero-extend.
  - Result is registered; mem_data_ready (or mc_inst_ready) pulses in cycle T+n+2, then the block returns to IDLE.
  - LW has 6-cycle latency from issue.
- STORE:
  - mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k] in cycles T+1..T+n, then IDLE.
  - If addr >= IO_ADDR and io_buffer_full=1, the byte is not driven (mem_wr=0) and k does not advance until io_buffer_full=0.
- Idle bus: mem_wr=0 and mem_a=0.
- Address arithmetic is modulo 2^`XLEN.
- Flush:
  - In-progress LOAD or FETCH aborts: state goes to IDLE next cycle and the load slot clears.
  - No ready pulse is emitted in or after the flush cycle for the aborted access.
  - A ready pulse already scheduled for the flush cycle itself is suppressed.
  - An in-progress STORE and a pending store are never aborted (they are committed).
  - A load pulse arriving in the flush cycle is dropped.
- rst mid-operation: immediate return to the reset state; a partial store is abandoned.
- rdy=0: all registers hold; mem_wr is forced to 0.
- mem_id always reflects the id of the load whose result is on mem_data.

Decomposition:
- Op encodings, `XLEN and id widths stay in global_params.v.
- Add to global_params.v: MC state encoding (IDLE, LOAD, STORE, FETCH) and `IO_ADDR.
- One natural sub-module: mc_load_extend (combinational byte assembly plus sign/zero extension by op).

Test Plan:
- RAM[0x100..0x103] = 11 22 33 44; LW at 0x100, id 5, issued at T → mem_a 0x100..0x103 in T+1..T+4; mem_data_ready at T+6 with mem_data 0x44332211, mem_id 5.
- RAM[0x104] = 0x80 → LB returns 0xFFFFFF80; LBU returns 0x00000080. LH on 0x80,0xFF → 0xFFFFFF80.
- SH 0xBEEF to 0x200, rob_mem_enable and lsb_mem_enable in the same cycle → writes EF@0x200 then BE@0x201 first; the load follows; mem_busy stays 1 throughout.
- SB 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then one write; the store is unaffected by a flush pulse during the wait.
- Flush 2 cycles into an LW → no mem_data_ready; the next if_enable at 0x0 returns mc_inst within 6 cycles.
- rst asserted mid-SW → all outputs 0 next cycle, mem_busy 0, state IDLE.
